data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
- REQ-001: Parameter DATA_W, default 64, memory word width in bits; SHALL be 32 or 64.
- REQ-002: Parameter DEPTH, default 256, number of words; SHALL be a power of two.
- REQ-003: Parameter RD_LAT, default 1, read latency in cycles; SHALL be 1..4.
- REQ-004: clk  input  1  sole clock, rising-edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: req_valid  input  1  request present.
- REQ-007: req_ready  output  1  controller can accept a request.
- REQ-008: req_we  input  1  1 = store, 0 = load.
- REQ-009: req_addr  input  64  byte address.
- REQ-010: req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double (3 is illegal when DATA_W = 32).
- REQ-011: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- REQ-012: req_wdata  input  DATA_W  store data, right-aligned.
- REQ-013: rsp_valid  output  1  response present.
- REQ-014: rsp_ready  input  1  consumer accepts response.
- REQ-015: rsp_rdata  output  DATA_W  load result, extended; 0 for stores.
- REQ-016: rsp_err  output  1  access error flag.

Function
- REQ-017: FSM states SHALL be IDLE, WAIT, RESP; at most one transaction outstanding.
- REQ-018: req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
- REQ-019: Word index SHALL be (req_addr >> log2(DATA_W/8)) mod DEPTH; addresses beyond DEPTH wrap silently.
- REQ-020: Byte offset SHALL be req_addr[log2(DATA_W/8)-1:0].
- REQ-021: A store SHALL update only the 2^req_size byte lanes starting at the offset, on the accept edge; the FSM then enters RESP.
- REQ-022: A load SHALL enter WAIT, count RD_LAT-1 further cycles, capture the word, shift it right by offset*8, extend per req_unsigned, and enter RESP; rsp_valid rises exactly RD_LAT cycles after acceptance.
- REQ-023: Load and store request fields SHALL be registered at acceptance; later input changes have no effect.
- REQ-024: In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid && rsp_ready; the FSM then returns to IDLE (no same-cycle re-accept).
- REQ-025: req_size = 3 with DATA_W = 32 SHALL complete with rsp_err = 1 and no memory write.
- REQ-026: Memory array contents SHALL NOT be cleared by reset; they are loadable by $readmemh from the bench.

Reset
- REQ-027: On rst_n low, state SHALL become IDLE immediately; req_ready = 0 while rst_n is low, 1 in the first cycle after release.
- REQ-028: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 during reset.
- REQ-029: A transaction in WAIT or RESP when reset asserts SHALL be abandoned with no response; a store already accepted remains written.

Configuration
- REQ-030: Macro DMEM_MISALIGN_CHK_EN defined: a request whose offset is not a multiple of 2^req_size SHALL complete with rsp_err = 1, rsp_rdata = 0, and no memory write.
- REQ-031: Macro DMEM_MISALIGN_CHK_EN undefined: low offset bits SHALL be cleared to size alignment, the access proceeds, and rsp_err is driven 0 except under REQ-025.

Verification
- REQ-032: Store double 0x2A to 0x10, load double 0x10, RD_LAT = 1 -> rsp_rdata = 0x2A, rsp_valid one cycle after load accept.
- REQ-033: Store byte 0x80 to 0x23 over a zeroed word, load byte signed 0x23 -> 0xFFFF_FFFF_FFFF_FF80; unsigned -> 0x80; load double 0x20 -> 0x0000_0000_8000_0000.
- REQ-034: RD_LAT = 3, load with rsp_ready held low 5 cycles -> rsp_valid at accept+3, rdata stable, req_ready = 0 until handshake.
- REQ-035: DEPTH = 256, store double 0xDEAD to 0x800, load double 0x0 -> 0xDEAD (wrap).
- REQ-036: Load half at 0x11 -> with DMEM_MISALIGN_CHK_EN: rsp_err = 1, rdata = 0; without: data from 0x10, rsp_err = 0.
- REQ-037: Assert rst_n low during WAIT -> no rsp_valid, req_ready = 1 one cycle after release, prior stores intact.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-port data memory controller with valid/ready request and response channels
// Optional macro DMEM_MISALIGN_CHK_EN: flag misaligned accesses as errors instead of aligning them down.
module data_mem_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [63:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);
  localparam logic DW64 = (DATA_W == 64);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        cnt_q;

  logic              accept;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  raw_off;
  logic [OFF_W-1:0]  low_mask;
  logic [OFF_W-1:0]  acc_off;
  logic              size_err;
  logic              req_err;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_shift;
  logic              rd_top;
  logic              rd_sign;
  logic [DATA_W-1:0] load_ext;
  int                nbits;
  logic              unused_addr_hi;

  assign req_ready = rst_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  // Upper address bits fall off the end of the array: accesses wrap.
  assign req_idx        = req_addr[OFF_W +: IDX_W];
  assign raw_off        = req_addr[OFF_W-1:0];
  assign unused_addr_hi = ^req_addr[63:OFF_W+IDX_W];
  assign size_err       = !DW64 && (req_size == 2'd3);

  always_comb begin
    low_mask = '0;
    for (int i = 0; i < OFF_W; i++) begin
      low_mask[i] = (i < int'(req_size));
    end
  end

  assign acc_off = raw_off & ~low_mask;

`ifdef DMEM_MISALIGN_CHK_EN
  logic misalign;
  assign misalign = |(raw_off & low_mask);
  assign req_err  = size_err || misalign;
`else
  assign req_err  = size_err;
`endif

  always_comb begin
    wr_be = '0;
    for (int b = 0; b < NB; b++) begin
      wr_be[b] = (b >= int'(acc_off)) && (b < int'(acc_off) + (1 << req_size));
    end
  end

  assign wr_data = req_wdata << {acc_off, 3'b000};

  always_comb begin
    rd_shift = mem[idx_q] >> {off_q, 3'b000};
    case (size_q)
      2'd0:    rd_top = rd_shift[7];
      2'd1:    rd_top = rd_shift[15];
      2'd2:    rd_top = rd_shift[31];
      default: rd_top = rd_shift[DATA_W-1];
    endcase
    rd_sign = rd_top && !uns_q;
    nbits   = 8 << size_q;
    for (int i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i < nbits) ? rd_shift[i] : rd_sign;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_we ? RESP : WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q  <= req_idx;
        off_q  <= acc_off;
        size_q <= req_size;
        uns_q  <= req_unsigned;
        err_q  <= req_err;
        cnt_q  <= CNT_INIT;
        if (req_we) begin
          rsp_rdata <= '0;
          rsp_err   <= req_err;
        end
      end else if (state_q == WAIT) begin
        if (cnt_q != 2'd0) begin
          cnt_q <= cnt_q - 2'd1;
        end else begin
          rsp_rdata <= err_q ? '0 : load_ext;
          rsp_err   <= err_q;
        end
      end
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl against a byte-addressed reference model
module tb_data_mem_ctrl;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] byte_mem [0:2047];

  data_mem_ctrl #(.DATA_W(64), .DEPTH(256), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory seen as 2 KiB of bytes; loads assemble bytes little-endian.
  task automatic model(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata,
                       output logic [63:0] rdata, output logic err);
    int nb, base;
    logic [63:0] v, t;
    nb = 1 << size;
    base = int'(addr[10:0]);
    err = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    if (base % nb != 0) err = 1'b1;
`endif
    base = base - (base % nb);
    v = '0;
    if (!err) begin
      for (int k = 0; k < nb; k++) begin
        if (we) byte_mem[base+k] = wdata[8*k +: 8];
        else    v = v | (64'(byte_mem[base+k]) << (8*k));
      end
      t = v >> (8*nb - 1);
      if (!we && !uns && nb < 8 && t[0]) v = v | (~64'd0 << (8*nb));
    end
    rdata = v;
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata, input int hold,
                       output logic [63:0] obs);
    logic [63:0] exp_d;
    logic        exp_e;
    int          lat, waitc;
    model(we, addr, size, uns, wdata, exp_d, exp_e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_addr = {$urandom, $urandom};
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata = {$urandom, $urandom};
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk(we ? "store_latency" : "load_latency", 64'(lat), we ? 64'd0 : 64'(RD_LAT));
    obs = rsp_rdata;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_rdata", rsp_rdata, exp_d);
      chk("rsp_err", 64'(rsp_err), 64'(exp_e));
      chk("ready_busy", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_hs", 64'(req_ready), 64'd1);
    chk("valid_after_hs", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] obs;

    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    chk("reset_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_post_reset", 64'(req_ready), 64'd1);

    for (int i = 0; i < 256; i++) issue(1'b1, 64'(i*8), 2'd3, 1'b0, 64'd0, 0, obs);

    issue(1'b1, 64'h10, 2'd3, 1'b0, 64'h2A, 0, obs);
    issue(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0, obs);
    chk("dbl_roundtrip", obs, 64'h2A);

    issue(1'b1, 64'h23, 2'd0, 1'b0, 64'h80, 0, obs);
    issue(1'b0, 64'h23, 2'd0, 1'b0, 64'd0, 0, obs);
    chk("byte_signed", obs, 64'hFFFF_FFFF_FFFF_FF80);
    issue(1'b0, 64'h23, 2'd0, 1'b1, 64'd0, 0, obs);
    chk("byte_unsigned", obs, 64'h80);
    issue(1'b0, 64'h20, 2'd3, 1'b0, 64'd0, 0, obs);
    chk("byte_in_word", obs, 64'h0000_0000_8000_0000);

    issue(1'b0, 64'h20, 2'd3, 1'b1, 64'd0, 5, obs);
    chk("held_rdata", obs, 64'h0000_0000_8000_0000);

    issue(1'b1, 64'h800, 2'd3, 1'b0, 64'hDEAD, 0, obs);
    issue(1'b0, 64'h0, 2'd3, 1'b0, 64'd0, 0, obs);
    chk("addr_wrap", obs, 64'hDEAD);

    issue(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 0, obs);
    issue(1'b0, 64'h11, 2'd1, 1'b0, 64'd0, 0, obs);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("misaligned_half", obs, 64'h0);
`else
    chk("misaligned_half", obs, 64'h7788);
`endif

    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom), {$urandom, $urandom}, 2'($urandom), 1'($urandom),
            {$urandom, $urandom}, int'($urandom_range(0, 3)), obs);
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h20; req_size = 2'd3; req_unsigned = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_no_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'd0);
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rdata", rsp_rdata, 64'd0);
    chk("midrst_err", 64'(rsp_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", 64'(req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abandoned_no_rsp", 64'(rsp_valid), 64'd0);
    end

    issue(1'b0, 64'h0, 2'd3, 1'b1, 64'd0, 0, obs);
    issue(1'b0, 64'h10, 2'd3, 1'b1, 64'd0, 0, obs);
    issue(1'b0, 64'h20, 2'd3, 1'b1, 64'd0, 0, obs);
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 64'($urandom_range(0, 255) * 8), 2'd3, 1'b1, 64'd0, 0, obs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
